// File: rtl/decode_regfile_pkg.sv
// Shared definitions for the decode stage: ISA sizes, opcode constants,
// instruction field slices and the immediate extender.
package decode_regfile_pkg;

  localparam int ISA_WIDTH     = 32;
  localparam int REG_NUM       = 32;
  localparam int REG_IDX_WIDTH = $clog2(REG_NUM);
  localparam int RA_IDX        = 31;

  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E;

  typedef logic [ISA_WIDTH-1:0]     word_t;
  typedef logic [REG_IDX_WIDTH-1:0] reg_idx_t;

  function automatic logic [5:0] field_op(input word_t instr);
    return instr[31:26];
  endfunction

  function automatic reg_idx_t field_rs(input word_t instr);
    return instr[25:21];
  endfunction

  function automatic reg_idx_t field_rt(input word_t instr);
    return instr[20:16];
  endfunction

  function automatic reg_idx_t field_rd(input word_t instr);
    return instr[15:11];
  endfunction

  function automatic logic [15:0] field_imm(input word_t instr);
    return instr[15:0];
  endfunction

  // Logical immediates are zero-extended; everything else (including sltiu
  // and lui) is sign-extended.
  function automatic word_t imm_extend(input word_t instr);
    logic [5:0]  op;
    logic [15:0] imm;
    op  = field_op(instr);
    imm = field_imm(instr);
    if (op == OP_ANDI || op == OP_ORI || op == OP_XORI) begin
      return {16'h0000, imm};
    end
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/decode_regfile_reg_file.sv
// General register file: synchronous write, two asynchronous read ports and
// a debug read port. Register 0 always reads zero; reset clears every entry.
module decode_regfile_reg_file #(
  parameter int REG_NUM = 32,
  parameter int WIDTH   = 32,
  parameter int IDX_W   = $clog2(REG_NUM)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             write_en,
  input  logic [IDX_W-1:0] write_addr,
  input  logic [WIDTH-1:0] write_data,
  input  logic [IDX_W-1:0] read_addr_1,
  input  logic [IDX_W-1:0] read_addr_2,
  input  logic [IDX_W-1:0] dbg_addr,
  output logic [WIDTH-1:0] read_data_1,
  output logic [WIDTH-1:0] read_data_2,
  output logic [WIDTH-1:0] dbg_data
);

  logic [WIDTH-1:0] regs [REG_NUM];

  // Reset clears the whole array and wins over a same-cycle write; writes
  // aimed at register 0 are dropped so it never holds a value.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs[i] <= '0;
      end
    end else if (write_en && (write_addr != '0)) begin
      regs[write_addr] <= write_data;
    end
  end

  // Reads are asynchronous with no bypass: a register being written this
  // cycle still shows its old value until the edge.
  always_comb begin
    read_data_1 = (read_addr_1 == '0) ? '0 : regs[read_addr_1];
    read_data_2 = (read_addr_2 == '0) ? '0 : regs[read_addr_2];
    dbg_data    = (dbg_addr    == '0) ? '0 : regs[dbg_addr];
  end

endmodule

// File: rtl/decode_regfile.sv
// Decode stage of the single-cycle MIPS core: field extraction, write-back
// destination and data selection, immediate extension, and the register file.
module decode_regfile
  import decode_regfile_pkg::*;
#(
  parameter int REG_NUM = decode_regfile_pkg::REG_NUM,
  parameter int WIDTH   = decode_regfile_pkg::ISA_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] instruction,
  input  logic [WIDTH-1:0] link_addr,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [WIDTH-1:0] mem_data,
  input  logic             reg_write,
  input  logic             mem_to_reg,
  input  logic             reg_dst,
  input  logic             jal,
  input  logic [4:0]       dbg_addr,
  output logic [WIDTH-1:0] read_data_1,
  output logic [WIDTH-1:0] read_data_2,
  output logic [WIDTH-1:0] imm_extended,
  output logic [WIDTH-1:0] dbg_data
);

  localparam logic [4:0] RA = 5'(RA_IDX);

  logic [4:0]       rs;
  logic [4:0]       rt;
  logic [4:0]       rd;
  logic [4:0]       write_addr;
  logic [WIDTH-1:0] write_data;
  logic             write_en;

  assign rs = field_rs(instruction);
  assign rt = field_rt(instruction);
  assign rd = field_rd(instruction);

  // jal overrides both muxes: it always links $31 with PC+4, even when the
  // controller also asserts reg_write with reg_dst selecting rd.
  always_comb begin
    write_en   = reg_write | jal;
    write_addr = rt;
    write_data = alu_result;
    if (jal) begin
      write_addr = RA;
      write_data = link_addr;
    end else begin
      if (reg_dst) write_addr = rd;
      if (mem_to_reg) write_data = mem_data;
    end
  end

  // Immediate extension depends only on the opcode of the current instruction.
  always_comb begin
    imm_extended = imm_extend(instruction);
  end

  decode_regfile_reg_file #(
    .REG_NUM (REG_NUM),
    .WIDTH   (WIDTH),
    .IDX_W   (5)
  ) u_reg_file (
    .clock       (clock),
    .reset       (reset),
    .write_en    (write_en),
    .write_addr  (write_addr),
    .write_data  (write_data),
    .read_addr_1 (rs),
    .read_addr_2 (rt),
    .dbg_addr    (dbg_addr),
    .read_data_1 (read_data_1),
    .read_data_2 (read_data_2),
    .dbg_data    (dbg_data)
  );

endmodule

// File: tb/tb_decode_regfile.sv
// Bench for decode_regfile: table-driven immediate checks, hand-written
// write-back sequences, then randomized cycles against a register-array model.
`timescale 1ns/1ps
module tb_decode_regfile;

  logic        clock;
  logic        reset;
  logic [31:0] instruction;
  logic [31:0] link_addr;
  logic [31:0] alu_result;
  logic [31:0] mem_data;
  logic        reg_write;
  logic        mem_to_reg;
  logic        reg_dst;
  logic        jal;
  logic [4:0]  dbg_addr;
  logic [31:0] read_data_1;
  logic [31:0] read_data_2;
  logic [31:0] imm_extended;
  logic [31:0] dbg_data;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_regs [32];

  decode_regfile dut (
    .clock        (clock),
    .reset        (reset),
    .instruction  (instruction),
    .link_addr    (link_addr),
    .alu_result   (alu_result),
    .mem_data     (mem_data),
    .reg_write    (reg_write),
    .mem_to_reg   (mem_to_reg),
    .reg_dst      (reg_dst),
    .jal          (jal),
    .dbg_addr     (dbg_addr),
    .read_data_1  (read_data_1),
    .read_data_2  (read_data_2),
    .imm_extended (imm_extended),
    .dbg_data     (dbg_data)
  );

  // clock / reset block
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    reset       = 1'b1;
    instruction = '0;
    link_addr   = '0;
    alu_result  = '0;
    mem_data    = '0;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    reg_dst     = 1'b0;
    jal         = 1'b0;
    dbg_addr    = '0;
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_imm(input logic [31:0] instr);
    int unsigned op;
    int unsigned imm;
    op  = instr >> 26;
    imm = instr & 32'hFFFF;
    if (op == 12 || op == 13 || op == 14) return imm;
    if (imm >= 32768) return imm + 32'hFFFF_0000;
    return imm;
  endfunction

  function automatic logic [31:0] ref_read(input int idx);
    if (idx == 0) return 32'h0;
    return model_regs[idx];
  endfunction

  // Apply the architectural write-back rule for the inputs currently driven.
  task automatic model_commit();
    int dest;
    logic [31:0] data;
    if (reset) begin
      for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
    end else if (reg_write || jal) begin
      if (jal) begin
        dest = 31;
        data = link_addr;
      end else begin
        dest = reg_dst ? int'(instruction[15:11]) : int'(instruction[20:16]);
        data = mem_to_reg ? mem_data : alu_result;
      end
      if (dest != 0) model_regs[dest] = data;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic expect_val(input logic [31:0] exp);
    exp_q.push_back(exp);
  endtask

  task automatic compare(input string name, input logic [31:0] act);
    logic [31:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: no expectation queued, actual %h", name, act);
      return;
    end
    exp = exp_q.pop_front();
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    expect_val(exp);
    compare(name, act);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [31:0] instr, input logic [31:0] link,
                       input logic [31:0] alu, input logic [31:0] mem,
                       input logic rw, input logic m2r, input logic rdst,
                       input logic j, input logic rst);
    @(negedge clock);
    instruction = instr;
    link_addr   = link;
    alu_result  = alu;
    mem_data    = mem;
    reg_write   = rw;
    mem_to_reg  = m2r;
    reg_dst     = rdst;
    jal         = j;
    reset       = rst;
    #1;
  endtask

  task automatic tick();
    model_commit();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    drive(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] r_type(input int rs, input int rt, input int rd);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 11'h0};
  endfunction

  function automatic logic [31:0] i_type(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic [31:0] exp_imm;
    string       name;
  } imm_vec_t;

  imm_vec_t imm_vecs [8];

  initial begin
    imm_vecs[0] = '{32'h2000_8001, 32'hFFFF_8001, "imm_addi_neg"};
    imm_vecs[1] = '{32'h3400_8001, 32'h0000_8001, "imm_ori_zext"};
    imm_vecs[2] = '{32'h3000_FFFF, 32'h0000_FFFF, "imm_andi_zext"};
    imm_vecs[3] = '{32'h3800_8000, 32'h0000_8000, "imm_xori_zext"};
    imm_vecs[4] = '{32'h2C00_8000, 32'hFFFF_8000, "imm_sltiu_sext"};
    imm_vecs[5] = '{32'h3C00_F00F, 32'hFFFF_F00F, "imm_lui_sext"};
    imm_vecs[6] = '{32'h2000_7FFF, 32'h0000_7FFF, "imm_addi_pos"};
    imm_vecs[7] = '{32'h8C00_FFFF, 32'hFFFF_FFFF, "imm_lw_sext"};

    for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;

    // Reset held two cycles: every register and both read ports are zero.
    drive(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      check($sformatf("reset_dbg_%0d", i), dbg_data, 32'h0);
    end
    check("reset_rd1", read_data_1, 32'h0);
    check("reset_rd2", read_data_2, 32'h0);
    check("reset_imm", imm_extended, 32'h0);
    idle();

    // Immediate extension table.
    for (int i = 0; i < 8; i++) begin
      drive(imm_vecs[i].instr, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check(imm_vecs[i].name, imm_extended, imm_vecs[i].exp_imm);
      check({imm_vecs[i].name, "_model"}, imm_extended, ref_imm(imm_vecs[i].instr));
    end

    // R-type write-back: visible only after the edge.
    drive(r_type(5, 0, 5), 32'h0, 32'hDEAD_BEEF, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("rtype_before_edge", read_data_1, 32'h0);
    tick();
    check("rtype_after_edge", read_data_1, 32'hDEAD_BEEF);

    // $0 protect via I-type with rt = 0.
    drive(i_type(8, 0, 0, 1), 32'h0, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    dbg_addr = 5'd0;
    #1;
    check("zero_protect_dbg", dbg_data, 32'h0);
    check("zero_protect_rd2", read_data_2, 32'h0);

    // jal with reg_write and reg_dst also asserted: $31 linked, $7 untouched.
    drive(r_type(0, 0, 7), 32'h0000_0104, 32'h0000_0777, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    dbg_addr = 5'd31;
    #1;
    check("jal_ra", dbg_data, 32'h0000_0104);
    dbg_addr = 5'd7;
    #1;
    check("jal_rd_untouched", dbg_data, 32'h0);

    // Load path into rt = 9.
    drive(i_type(35, 0, 9, 0), 32'h0, 32'h1234_5678, 32'h0000_00A5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    dbg_addr = 5'd9;
    #1;
    check("load_rt9", dbg_data, 32'h0000_00A5);

    // Unknowns on the write-side inputs with no enable leave registers alone.
    drive(r_type(9, 5, 9), 'x, 'x, 'x, 1'b0, 1'bx, 1'bx, 1'b0, 1'b0);
    tick();
    check("x_inputs_rd1", read_data_1, 32'h0000_00A5);
    check("x_inputs_rd2", read_data_2, 32'hDEAD_BEEF);

    // Reset on the same edge as a write: target stays zero, all cleared.
    drive(r_type(12, 9, 12), 32'h0, 32'hCAFE_F00D, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    dbg_addr = 5'd12;
    #1;
    check("reset_mid_write_target", dbg_data, 32'h0);
    check("reset_mid_write_clears", read_data_2, 32'h0);
    idle();

    // Randomized cycles against the model.
    for (int n = 0; n < 300; n++) begin
      logic [31:0] instr;
      logic rw, j, rst;
      instr = $urandom();
      rw    = ($urandom_range(0, 3) != 0);
      j     = ($urandom_range(0, 9) == 0);
      rst   = ($urandom_range(0, 39) == 0);
      drive(instr, $urandom(), $urandom(), $urandom(), rw,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), j, rst);
      dbg_addr = 5'($urandom_range(0, 31));
      #1;
      check("rand_rd1", read_data_1, ref_read(int'(instr[25:21])));
      check("rand_rd2", read_data_2, ref_read(int'(instr[20:16])));
      check("rand_imm", imm_extended, ref_imm(instr));
      check("rand_dbg", dbg_data, ref_read(int'(dbg_addr)));
      tick();
    end

    // Final sweep of every register against the model.
    idle();
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      check($sformatf("final_dbg_%0d", i), dbg_data, ref_read(i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, checks %0d", checks);
    $fatal(1);
  end

endmodule
